present_sbox_layer_pipe: RTL and testbench

//  Parametrised, stallable PRESENT substitution layer: NLANE 4-bit S-box lanes in parallel, fixed 3-stage pipeline.
//  Per-beat mode bit selects forward S or inverse S^-1, so one instance serves encryption and decryption rounds.

---
 rtl/present_pkg.sv | 40 ++++
 rtl/present_sbox_lane.sv | 62 ++++++
 rtl/present_sbox_layer_pipe.sv | 83 ++++++++
 tb/tb_present_sbox_layer_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// present_pkg : PRESENT S-box tables, lane geometry and ANF helper | rev 1.0
// ============================================================================
package present_pkg;

   localparam int LANE_W     = 4;
   localparam int PIPE_DEPTH = 3;

   localparam logic [3:0] SBOX_FWD [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] SBOX_INV [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   // Algebraic normal form of one output bit: bit m set means monomial
   // prod(x_k for k in m) appears in the XOR sum (Moebius transform).
   function automatic logic [15:0] sbox_anf(input logic inv, input int bitn);
      logic [15:0] a;
      logic [3:0]  t;
      logic [3:0]  xi;
      logic [3:0]  mi;
      a = '0;
      for (int m = 0; m < 16; m++) begin
         mi = 4'(m);
         for (int x = 0; x < 16; x++) begin
            xi = 4'(x);
            t  = inv ? SBOX_INV[xi] : SBOX_FWD[xi];
            if ((xi & ~mi) == 4'd0) a[mi] = a[mi] ^ t[bitn[1:0]];
         end
      end
      return a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/present_sbox_lane.sv
`default_nettype none
// ============================================================================
// present_sbox_lane : one 4-bit forward/inverse S-box lane, 3 registered stages | rev 1.0
// ============================================================================
module present_sbox_lane
   import present_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              inv,
   input  logic [LANE_W-1:0] din,
   output logic [LANE_W-1:0] dout
);

   logic [3:0]  r_x;
   logic [5:0]  r_p;
   logic [15:0] r_mono;
   logic [3:0]  r_out;
   logic [15:0] w_mono;
   logic [3:0]  w_sub;

   // r_p pairs: 0=x0x1 1=x0x2 2=x0x3 3=x1x2 4=x1x3 5=x2x3
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_p <= '0;
      end else if (en) begin
         r_x <= din;
         r_p <= {din[2] & din[3], din[1] & din[3], din[1] & din[2],
                 din[0] & din[3], din[0] & din[2], din[0] & din[1]};
      end
   end

   always_comb begin
      w_mono = {r_p[0] & r_p[5], r_p[3] & r_x[3], r_p[1] & r_x[3], r_p[5],
                r_p[0] & r_x[3], r_p[4],          r_p[2],          r_x[3],
                r_p[0] & r_x[2], r_p[3],          r_p[1],          r_x[2],
                r_p[0],          r_x[1],          r_x[0],          1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_mono <= '0;
      else if (en) r_mono <= w_mono;
   end

   // inv belongs to the beat currently held in the monomial stage
   for (genvar b = 0; b < 4; b++) begin : g_bit
      localparam logic [15:0] C_FWD = sbox_anf(1'b0, b);
      localparam logic [15:0] C_INV = sbox_anf(1'b1, b);
      assign w_sub[b] = inv ? ^(r_mono & C_INV) : ^(r_mono & C_FWD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out <= '0;
      else if (en) r_out <= w_sub;
   end

   assign dout = r_out;

endmodule
`default_nettype wire

// File: rtl/present_sbox_layer_pipe.sv
`default_nettype none
// ============================================================================
// present_sbox_layer_pipe : stallable NLANE-wide PRESENT S/S^-1 layer, 3-stage | rev 1.0
// ============================================================================
module present_sbox_layer_pipe
   import present_pkg::*;
#(
   parameter int NLANE = 16,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_inv,
   input  logic [4*NLANE-1:0]      in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_inv,
   output logic [4*NLANE-1:0]      out_data,
   output logic [CNT_W-1:0]        beat_cnt
);

   logic             w_adv;
   logic             r_v1, r_v2, r_v3;
   logic             r_m1, r_m2, r_m3;
   logic [CNT_W-1:0] r_cnt;

   assign w_adv    = ~r_v3 | out_ready;
   assign in_ready = w_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else if (flush) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else if (w_adv) begin
         r_v1 <= in_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m1 <= 1'b0;
         r_m2 <= 1'b0;
         r_m3 <= 1'b0;
      end else if (w_adv) begin
         r_m1 <= in_inv;
         r_m2 <= r_m1;
         r_m3 <= r_m2;
      end
   end

   // A handshake in a flush cycle still counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (r_v3 && out_ready && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
   end

   for (genvar i = 0; i < NLANE; i++) begin : g_lane
      present_sbox_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (w_adv),
         .inv   (r_m2),
         .din   (in_data[LANE_W*i +: LANE_W]),
         .dout  (out_data[LANE_W*i +: LANE_W])
      );
   end

   assign out_valid = r_v3;
   assign out_inv   = r_m3;
   assign beat_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_present_sbox_layer_pipe.sv
`default_nettype none
// ============================================================================
// tb_present_sbox_layer_pipe : scoreboard bench for the PRESENT S-box layer | rev 1.0
// ============================================================================
module tb_present_sbox_layer_pipe;
   import present_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_inv = 1'b0;
   logic [63:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_inv;
   logic [63:0] out_data;
   logic [15:0] beat_cnt;

   logic        s_valid = 1'b0;
   logic        s_in_ready;
   logic        s_out_valid;
   logic        s_out_inv;
   logic [3:0]  s_out_data;
   logic [3:0]  s_cnt;

   typedef struct packed {
      logic        inv;
      logic [63:0] data;
   } beat_t;

   beat_t sb[$];
   int    tests_run = 0;
   int    tests_failed = 0;
   int    exp_cnt = 0;
   int    cyc = 0;
   int    first_out = -1;
   int    last_out = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   present_sbox_layer_pipe #(.NLANE(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data),
      .beat_cnt(beat_cnt)
   );

   present_sbox_layer_pipe #(.NLANE(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(s_valid), .in_ready(s_in_ready), .in_inv(1'b0), .in_data(4'h0),
      .out_valid(s_out_valid), .out_ready(1'b1), .out_inv(s_out_inv), .out_data(s_out_data),
      .beat_cnt(s_cnt)
   );

   function automatic logic [63:0] ref_sub(input logic inv, input logic [63:0] d);
      logic [63:0] r;
      logic [3:0]  n;
      for (int i = 0; i < 16; i++) begin
         n = d[4*i +: 4];
         r[4*i +: 4] = inv ? SBOX_INV[n] : SBOX_FWD[n];
      end
      return r;
   endfunction

   // Scoreboard: pop on output handshake, push on accepted input
   always @(negedge clk) begin
      beat_t e;
      beat_t nb;
      if (!rst_n) begin
         sb.delete();
         exp_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            tests_run++;
            exp_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_unexpected: got inv=%0b data=%h, expected no beat", out_inv, out_data);
            end else begin
               e = sb.pop_front();
               if ({out_inv, out_data} !== {e.inv, e.data}) begin
                  tests_failed++;
                  $display("FAIL sb_beat: got inv=%0b data=%h, expected inv=%0b data=%h",
                           out_inv, out_data, e.inv, e.data);
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) begin
            nb.inv  = in_inv;
            nb.data = ref_sub(in_inv, in_data);
            sb.push_back(nb);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && sb.size() != 0; k++) step();
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      #3;
      tests_run++;
      if ({out_valid, out_inv, out_data, beat_cnt, in_ready} !== {1'b0, 1'b0, 64'h0, 16'h0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_state: got v=%0b inv=%0b data=%h cnt=%0d rdy=%0b, expected 0/0/0/0/1",
                  out_valid, out_inv, out_data, beat_cnt, in_ready);
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      s_valid   = 1'b1;
      step();
   endtask

   task automatic test_single(input logic inv, input logic [63:0] din,
                              input logic [63:0] dexp, input logic [15:0] cnt_exp);
      in_valid = 1'b1;
      in_inv   = inv;
      in_data  = din;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: got out_valid=%0b at edge %0d, expected 0", out_valid, k);
         end
         step();
      end
      tests_run++;
      if ({out_valid, out_inv, out_data} !== {1'b1, inv, dexp}) begin
         tests_failed++;
         $display("FAIL single_out: got v=%0b inv=%0b data=%h, expected v=1 inv=%0b data=%h",
                  out_valid, out_inv, out_data, inv, dexp);
      end
      step();
      tests_run++;
      if (beat_cnt !== cnt_exp) begin
         tests_failed++;
         $display("FAIL single_cnt: got %0d, expected %0d", beat_cnt, cnt_exp);
      end
   endtask

   task automatic test_forward();
      test_single(1'b0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 16'd1);
   endtask

   task automatic test_inverse();
      test_single(1'b1, 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF, 16'd2);
   endtask

   task automatic test_back_to_back();
      int base;
      base = exp_cnt;
      first_out = -1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_inv   = (i % 2 == 1);
         in_data  = {$urandom, $urandom};
         step();
      end
      in_valid = 1'b0;
      drain();
      tests_run++;
      if (last_out - first_out != 19) begin
         tests_failed++;
         $display("FAIL stream_span: got %0d cycles first-to-last, expected 19", last_out - first_out);
      end
      tests_run++;
      if (beat_cnt !== 16'(base + 20)) begin
         tests_failed++;
         $display("FAIL stream_cnt: got %0d, expected %0d", beat_cnt, base + 20);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] beats [4];
      logic [63:0] held;
      logic        acc;
      int          idx;
      int          base;
      idx  = 0;
      base = exp_cnt;
      held = '0;
      for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
      for (int k = 0; k < 14; k++) begin
         in_valid  = (idx < 4);
         in_data   = beats[(idx < 4) ? idx : 0];
         in_inv    = 1'b0;
         out_ready = !(k >= 3 && k <= 7);
         #1;
         if (k == 3) held = out_data;
         if (k >= 3 && k <= 7) begin
            tests_run++;
            if ({out_valid, in_ready} !== 2'b10) begin
               tests_failed++;
               $display("FAIL bp_stall: got out_valid=%0b in_ready=%0b at k=%0d, expected 1/0",
                        out_valid, in_ready, k);
            end
         end
         if (k > 3 && k <= 7) begin
            tests_run++;
            if (out_data !== held) begin
               tests_failed++;
               $display("FAIL bp_hold: got %h at k=%0d, expected %h", out_data, k, held);
            end
         end
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      tests_run++;
      if (idx != 4 || beat_cnt !== 16'(base + 4)) begin
         tests_failed++;
         $display("FAIL bp_count: got accepted=%0d cnt=%0d, expected 4 and %0d", idx, beat_cnt, base + 4);
      end
   endtask

   task automatic test_flush();
      int          cnt0;
      logic [63:0] d;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_inv   = (k == 1);
         in_data  = {$urandom, $urandom};
         step();
      end
      cnt0      = exp_cnt;
      in_data   = {$urandom, $urandom};
      out_ready = 1'b0;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tests_run++;
      if (beat_cnt !== 16'(cnt0)) begin
         tests_failed++;
         $display("FAIL flush_cnt: got %0d, expected %0d", beat_cnt, cnt0);
      end
      for (int j = 0; j < 4; j++) begin
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_empty: got out_valid=%0b %0d cycles after flush, expected 0", out_valid, j);
         end
         step();
      end
      d = {$urandom, $urandom};
      test_single(1'b1, d, ref_sub(1'b1, d), 16'(cnt0 + 1));
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_inv   = 1'b0;
         in_data  = {$urandom, $urandom};
         step();
      end
      tests_run++;
      if ({out_valid, s_cnt} !== {1'b1, 4'hF}) begin
         tests_failed++;
         $display("FAIL pre_reset: got out_valid=%0b sat_cnt=%h, expected 1 and F", out_valid, s_cnt);
      end
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      tests_run++;
      if ({out_valid, beat_cnt, out_data, s_cnt} !== {1'b0, 16'h0, 64'h0, 4'h0}) begin
         tests_failed++;
         $display("FAIL async_reset: got v=%0b cnt=%0d data=%h sat_cnt=%h, expected all 0",
                  out_valid, beat_cnt, out_data, s_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_emit: got out_valid=%0b %0d cycles after reset, expected 0", out_valid, j);
         end
         step();
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 25; k++) step();
      tests_run++;
      if ({s_cnt, s_out_valid, s_out_data} !== {4'hF, 1'b1, 4'hC}) begin
         tests_failed++;
         $display("FAIL saturate: got cnt=%h v=%0b data=%h, expected F/1/C", s_cnt, s_out_valid, s_out_data);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
